// File: rtl/mesi_isc_mem_ctrl.sv
// mesi_isc_mem_ctrl: round-robin main-memory controller for the four CPU main-bus ports
// Ports: clk, rst (async, active-low); mbus_cmd_i/mbus_addr_i/mbus_data_wr_i carry one slice per CPU;
//        mbus_ack_o one-hot ack pulse, mbus_data_rd_o read data, busy_o access in flight,
//        addr_err_o out-of-range pulse, stat_rd_o/stat_wr_o 16-bit saturating per-CPU counters.
module mesi_isc_mem_ctrl #(
   parameter int MBUS_CMD_WIDTH = 3,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int MEM_DEPTH      = 10,
   parameter int MEM_LAT        = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [4*MBUS_CMD_WIDTH-1:0] mbus_cmd_i,
   input  logic [4*ADDR_WIDTH-1:0]     mbus_addr_i,
   input  logic [4*DATA_WIDTH-1:0]     mbus_data_wr_i,
   output logic [3:0]                  mbus_ack_o,
   output logic [DATA_WIDTH-1:0]       mbus_data_rd_o,
   output logic                        busy_o,
   output logic                        addr_err_o,
   output logic [4*16-1:0]             stat_rd_o,
   output logic [4*16-1:0]             stat_wr_o
);
   localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [MBUS_CMD_WIDTH-1:0] CMD_WR = MBUS_CMD_WIDTH'(1);
   localparam logic [MBUS_CMD_WIDTH-1:0] CMD_RD = MBUS_CMD_WIDTH'(2);
   typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
   state_t                  state_q, state_d;
   logic [1:0]              pri_q, pri_d, idx_q, idx_d, gnt_idx;
   logic                    wr_q, wr_d, busy_q, busy_d, err_q, err_d, gnt_vld, in_rng;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
   logic [3:0]              lat_q, lat_d, ack_q, ack_d, req;
   logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];
   logic [DATA_WIDTH-1:0]   mem_d [MEM_DEPTH];
   logic [3:0][15:0]        st_rd_q, st_rd_d, st_wr_q, st_wr_d;
   logic [AW-1:0]           aidx;
   assign in_rng = addr_q < ADDR_WIDTH'(MEM_DEPTH);
   assign aidx   = addr_q[AW-1:0];
   // Broadcast and unknown commands belong to mesi_isc; only plain RD/WR request memory.
   always_comb begin
      for (int n = 0; n < 4; n++) begin
         req[n] = (mbus_cmd_i[n*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH] == CMD_WR) ||
                  (mbus_cmd_i[n*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH] == CMD_RD);
      end
   end
   // Scanning downwards lets the requester closest to pri overwrite the others.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (req[pri_q + 2'(i)]) begin
            gnt_vld = 1'b1;
            gnt_idx = pri_q + 2'(i);
         end
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         pri_q   <= '0;
         idx_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         lat_q   <= '0;
         ack_q   <= '0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         st_rd_q <= '0;
         st_wr_q <= '0;
         for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         pri_q   <= pri_d;
         idx_q   <= idx_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         lat_q   <= lat_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         st_rd_q <= st_rd_d;
         st_wr_q <= st_wr_d;
         mem_q   <= mem_d;
      end
   end
   always_comb begin
      state_d = state_q;
      if (state_q == IDLE && gnt_vld) state_d = ACCESS;
      else if (state_q == ACCESS && lat_q == '0) state_d = ACK;
      else if (state_q == ACK) state_d = IDLE;
   end
   always_comb begin
      pri_d   = pri_q;
      idx_d   = idx_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      lat_d   = lat_q;
      busy_d  = busy_q;
      st_rd_d = st_rd_q;
      st_wr_d = st_wr_q;
      mem_d   = mem_q;
      ack_d   = '0;
      err_d   = 1'b0;
      if (state_q == IDLE && gnt_vld) begin
         idx_d   = gnt_idx;
         wr_d    = mbus_cmd_i[32'(gnt_idx)*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH] == CMD_WR;
         addr_d  = mbus_addr_i[32'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
         wdata_d = mbus_data_wr_i[32'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
         // MEM_LAT wait edges, then the access edge itself: ack lands MEM_LAT+1 edges after grant.
         lat_d   = 4'(MEM_LAT);
         busy_d  = 1'b1;
      end else if (state_q == ACCESS) begin
         if (lat_q != '0) begin
            lat_d = lat_q - 4'd1;
         end else begin
            if (wr_q && in_rng) mem_d[aidx] = wdata_q;
            if (!wr_q) rdata_d = in_rng ? mem_q[aidx] : '0;
            ack_d[idx_q] = 1'b1;
            err_d        = !in_rng;
            if (wr_q) st_wr_d[idx_q] = (st_wr_q[idx_q] == 16'hFFFF) ? st_wr_q[idx_q] : st_wr_q[idx_q] + 16'd1;
            else      st_rd_d[idx_q] = (st_rd_q[idx_q] == 16'hFFFF) ? st_rd_q[idx_q] : st_rd_q[idx_q] + 16'd1;
         end
      end else if (state_q == ACK) begin
         busy_d = 1'b0;
         pri_d  = idx_q + 2'd1;
      end
   end
   assign mbus_ack_o     = ack_q;
   assign mbus_data_rd_o = rdata_q;
   assign busy_o         = busy_q;
   assign addr_err_o     = err_q;
   assign stat_rd_o      = st_rd_q;
   assign stat_wr_o      = st_wr_q;
endmodule
